// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage (master) and the
// iterative multiply/divide sequencer (slave).
interface muldiv_seq_if #(
  parameter int XLEN = 64
);
  logic            i_start;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_a;
  logic [XLEN-1:0] i_b;
  logic            i_flush;
  logic            o_stall;
  logic            o_busy;
  logic            o_done;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_start, i_op, i_a, i_b, i_flush,
    input  o_stall, o_busy, o_done, o_result
  );

  modport slave (
    input  i_start, i_op, i_a, i_b, i_flush,
    output o_stall, o_busy, o_done, o_result
  );
endinterface

// File: rtl/muldiv_seq.sv
// Radix-2 multiply/divide sequencer: one unsigned iteration per cycle over
// operand magnitudes, sign fixed up as the result register is loaded.
module muldiv_seq #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  muldiv_seq_if.slave   bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_hi, r_lo, r_b, r_result;
  logic             r_div, r_rem, r_hu, r_neg, r_done;

  // Request decode; reserved encodings fall through to plain MUL.
  logic            w_is_div, w_is_rem, w_signed, w_hu;
  logic            w_a_neg, w_b_neg, w_neg, w_b_zero, w_ovf, w_special;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_spec_res;

  assign w_is_div  = bus.i_op[2];
  assign w_is_rem  = bus.i_op[2] & bus.i_op[1];
  assign w_signed  = bus.i_op[2] & ~bus.i_op[0];
  assign w_hu      = (bus.i_op == 3'b001);
  assign w_a_neg   = w_signed & bus.i_a[XLEN-1];
  assign w_b_neg   = w_signed & bus.i_b[XLEN-1];
  assign w_a_mag   = w_a_neg ? (~bus.i_a + 1'b1) : bus.i_a;
  assign w_b_mag   = w_b_neg ? (~bus.i_b + 1'b1) : bus.i_b;
  assign w_neg     = w_is_rem ? w_a_neg : (w_a_neg ^ w_b_neg);
  assign w_b_zero  = (bus.i_b == '0);
  assign w_ovf     = w_signed & (bus.i_a == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.i_b);
  assign w_special = w_is_div & (w_b_zero | w_ovf);
  assign w_spec_res = w_b_zero ? (w_is_rem ? bus.i_a : '1)
                               : (w_is_rem ? '0 : bus.i_a);

  // One iteration: r_hi is product-high / remainder, r_lo is product-low /
  // dividend-shifting-into-quotient.
  logic [XLEN:0]   w_mul_sum, w_rem_sh, w_diff;
  logic            w_ge, w_last;
  logic [XLEN-1:0] w_hi_nx, w_lo_nx, w_raw, w_fin;

  assign w_mul_sum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : {XLEN{1'b0}})};
  assign w_rem_sh  = {r_hi, r_lo[XLEN-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_b};
  assign w_ge      = ~w_diff[XLEN];

  always_comb begin
    w_hi_nx = w_mul_sum[XLEN:1];
    w_lo_nx = {w_mul_sum[0], r_lo[XLEN-1:1]};
    if (r_div) begin
      w_hi_nx = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
      w_lo_nx = {r_lo[XLEN-2:0], w_ge};
    end
  end

  assign w_raw  = (r_div ? r_rem : r_hu) ? w_hi_nx : w_lo_nx;
  assign w_fin  = r_neg ? (~w_raw + 1'b1) : w_raw;
  assign w_last = (r_cnt == CNT_W'(XLEN-1));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_div    <= 1'b0;
      r_rem    <= 1'b0;
      r_hu     <= 1'b0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.i_flush) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (bus.i_start) begin
            if (w_special) begin
              r_result <= w_spec_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_hi    <= '0;
              r_lo    <= w_a_mag;
              r_b     <= w_b_mag;
              r_div   <= w_is_div;
              r_rem   <= w_is_rem;
              r_hu    <= w_hu;
              r_neg   <= w_neg;
              r_cnt   <= '0;
              r_state <= S_BUSY;
            end
          end
          S_BUSY: begin
            r_hi  <= w_hi_nx;
            r_lo  <= w_lo_nx;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_result <= w_fin;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.o_stall  = ((r_state == S_IDLE) & bus.i_start & ~bus.i_flush) |
                        (r_state == S_BUSY);
  assign bus.o_busy   = (r_state == S_BUSY);
  assign bus.o_done   = r_done;
  assign bus.o_result = r_result;
endmodule
